// File: rtl/tdc_pkg.sv
// Shared widths, calibration constant and status layout for the TDC hit decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

    // Default geometry of the TDC delay lines and coarse counter
    localparam int START_TAPS = 204;
    localparam int STOP_TAPS  = 176;
    localparam int COUNT_W    = 48;
    localparam int IDX_W      = 8;
    localparam int INT_W      = COUNT_W + 9;

    // Calibrated fine bins per coarse clock period
    localparam int CLK_BINS   = 200;

    // Bit positions inside the 3-bit status word
    localparam int ST_START_INV = 0;
    localparam int ST_STOP_INV  = 1;
    localparam int ST_NEG       = 2;

    // Status word; field order matches the bit positions above
    typedef struct packed {
        logic neg;
        logic stop_inv;
        logic start_inv;
    } status_t;

endpackage

// File: rtl/onehot_index_decode.sv
// Converts a tap vector into the lowest set index plus empty / multi-hit flags.
// Latency: combinational.
// Backpressure: none; pure function of the input vector.
module onehot_index_decode #(
    parameter int W     = 204,
    parameter int IDX_W = 8
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             none,
    output logic             multi
);

    // Priority search from the top down so the lowest set bit wins
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set
    assign none  = ~|vec;
    assign multi = |(vec & (vec - W'(1)));

endmodule

// File: rtl/tdc_hit_decoder.sv
// Decodes start/stop tap vectors plus coarse count into a binned interval with status.
// Latency: 3 cycles accept-to-result; one capture per cycle sustained.
// Backpressure: valid/ready per stage; in_ready is a combinational chain from res_ready.
// Optional error counter enabled by defining TDC_DEC_ERRCNT_EN.
module tdc_hit_decoder
    import tdc_pkg::*;
#(
    parameter int START_TAPS = tdc_pkg::START_TAPS,
    parameter int STOP_TAPS  = tdc_pkg::STOP_TAPS,
    parameter int COUNT_W    = tdc_pkg::COUNT_W,
    parameter int CLK_BINS   = tdc_pkg::CLK_BINS,
    parameter int IDX_W      = tdc_pkg::IDX_W,
    parameter int INT_W      = COUNT_W + 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [START_TAPS-1:0] one_hot_start,
    input  logic [STOP_TAPS-1:0]  one_hot_stop,
    input  logic [COUNT_W-1:0]    out_count,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [INT_W-1:0]      res_interval,
    output logic [IDX_W-1:0]      res_start_idx,
    output logic [IDX_W-1:0]      res_stop_idx,
    output logic [2:0]            res_status,
    output logic [15:0]           err_count
);

    // ---------------- stage state ----------------
    logic                  s1_vld_q,   s1_vld_d;
    logic [START_TAPS-1:0] s1_start_q, s1_start_d;
    logic [STOP_TAPS-1:0]  s1_stop_q,  s1_stop_d;
    logic [COUNT_W-1:0]    s1_count_q, s1_count_d;

    logic                  s2_vld_q,         s2_vld_d;
    logic [IDX_W-1:0]      s2_start_idx_q,   s2_start_idx_d;
    logic                  s2_start_inv_q,   s2_start_inv_d;
    logic [IDX_W-1:0]      s2_stop_idx_q,    s2_stop_idx_d;
    logic                  s2_stop_inv_q,    s2_stop_inv_d;
    logic [COUNT_W-1:0]    s2_count_q,       s2_count_d;

    logic                  s3_vld_q,       s3_vld_d;
    logic [INT_W-1:0]      s3_interval_q,  s3_interval_d;
    logic [IDX_W-1:0]      s3_start_idx_q, s3_start_idx_d;
    logic [IDX_W-1:0]      s3_stop_idx_q,  s3_stop_idx_d;
    status_t               s3_status_q,    s3_status_d;

    // ---------------- handshake chain ----------------
    // A stage may load when it is empty or its content moves on this cycle
    logic s1_load, s2_load, s3_load;

    assign s3_load  = !s3_vld_q || res_ready;
    assign s2_load  = !s2_vld_q || s3_load;
    assign s1_load  = !s1_vld_q || s2_load;
    assign in_ready = s1_load;

    // ---------------- S2 decode ----------------
    logic [IDX_W-1:0] dec_start_idx, dec_stop_idx;
    logic             dec_start_none, dec_start_multi;
    logic             dec_stop_none,  dec_stop_multi;

    onehot_index_decode #(
        .W     (START_TAPS),
        .IDX_W (IDX_W)
    ) u_dec_start (
        .vec   (s1_start_q),
        .idx   (dec_start_idx),
        .none  (dec_start_none),
        .multi (dec_start_multi)
    );

    onehot_index_decode #(
        .W     (STOP_TAPS),
        .IDX_W (IDX_W)
    ) u_dec_stop (
        .vec   (s1_stop_q),
        .idx   (dec_stop_idx),
        .none  (dec_stop_none),
        .multi (dec_stop_multi)
    );

    // ---------------- S3 arithmetic ----------------
    // One extra bit above INT_W acts as the sign; the product never reaches it
    logic [INT_W:0] coarse_bins;
    logic [INT_W:0] signed_sum;
    status_t        status_c;

    // Interval in fine bins plus the resulting status word
    always_comb begin
        coarse_bins        = (INT_W + 1)'(s2_count_q) * (INT_W + 1)'(CLK_BINS);
        signed_sum         = coarse_bins + (INT_W + 1)'(s2_start_idx_q)
                                         - (INT_W + 1)'(s2_stop_idx_q);
        status_c.start_inv = s2_start_inv_q;
        status_c.stop_inv  = s2_stop_inv_q;
        status_c.neg       = signed_sum[INT_W];
    end

    // Next-state for S1: capture the raw inputs on an input handshake
    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_start_d = s1_start_q;
        s1_stop_d  = s1_stop_q;
        s1_count_d = s1_count_q;
        if (s1_load) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_start_d = one_hot_start;
                s1_stop_d  = one_hot_stop;
                s1_count_d = out_count;
            end
        end
    end

    // Next-state for S2: register decoded indices and validity
    always_comb begin
        s2_vld_d       = s2_vld_q;
        s2_start_idx_d = s2_start_idx_q;
        s2_start_inv_d = s2_start_inv_q;
        s2_stop_idx_d  = s2_stop_idx_q;
        s2_stop_inv_d  = s2_stop_inv_q;
        s2_count_d     = s2_count_q;
        if (s2_load) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_start_idx_d = dec_start_idx;
                s2_start_inv_d = dec_start_none || dec_start_multi;
                s2_stop_idx_d  = dec_stop_idx;
                s2_stop_inv_d  = dec_stop_none || dec_stop_multi;
                s2_count_d     = s1_count_q;
            end
        end
    end

    // Next-state for S3: output register, interval zeroed on any flagged condition
    always_comb begin
        s3_vld_d       = s3_vld_q;
        s3_interval_d  = s3_interval_q;
        s3_start_idx_d = s3_start_idx_q;
        s3_stop_idx_d  = s3_stop_idx_q;
        s3_status_d    = s3_status_q;
        if (s3_load) begin
            s3_vld_d = s2_vld_q;
            if (s2_vld_q) begin
                s3_start_idx_d = s2_start_idx_q;
                s3_stop_idx_d  = s2_stop_idx_q;
                s3_status_d    = status_c;
                s3_interval_d  = (status_c != '0) ? '0 : signed_sum[INT_W-1:0];
            end
        end
    end

    // Pipeline registers; reset drops every in-flight capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q       <= 1'b0;
            s1_start_q     <= '0;
            s1_stop_q      <= '0;
            s1_count_q     <= '0;
            s2_vld_q       <= 1'b0;
            s2_start_idx_q <= '0;
            s2_start_inv_q <= 1'b0;
            s2_stop_idx_q  <= '0;
            s2_stop_inv_q  <= 1'b0;
            s2_count_q     <= '0;
            s3_vld_q       <= 1'b0;
            s3_interval_q  <= '0;
            s3_start_idx_q <= '0;
            s3_stop_idx_q  <= '0;
            s3_status_q    <= '0;
        end else begin
            s1_vld_q       <= s1_vld_d;
            s1_start_q     <= s1_start_d;
            s1_stop_q      <= s1_stop_d;
            s1_count_q     <= s1_count_d;
            s2_vld_q       <= s2_vld_d;
            s2_start_idx_q <= s2_start_idx_d;
            s2_start_inv_q <= s2_start_inv_d;
            s2_stop_idx_q  <= s2_stop_idx_d;
            s2_stop_inv_q  <= s2_stop_inv_d;
            s2_count_q     <= s2_count_d;
            s3_vld_q       <= s3_vld_d;
            s3_interval_q  <= s3_interval_d;
            s3_start_idx_q <= s3_start_idx_d;
            s3_stop_idx_q  <= s3_stop_idx_d;
            s3_status_q    <= s3_status_d;
        end
    end

    assign res_valid     = s3_vld_q;
    assign res_interval  = s3_interval_q;
    assign res_start_idx = s3_start_idx_q;
    assign res_stop_idx  = s3_stop_idx_q;
    assign res_status    = s3_status_q;

`ifdef TDC_DEC_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count flagged results as they leave, sticking at all-ones
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (s3_vld_q && res_ready && (s3_status_q != '0) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tdc_hit_decoder.sv
// Scoreboard bench for tdc_hit_decoder: directed captures, expectations queued at issue.
// Monitor samples on the falling edge; stimulus changes 1 time unit after the rising edge.
// Covers reset state, latency, throughput, decode/status corners, backpressure, reset mid-flight.
module tb_tdc_hit_decoder;
    import tdc_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [START_TAPS-1:0] one_hot_start;
    logic [STOP_TAPS-1:0]  one_hot_stop;
    logic [COUNT_W-1:0]    out_count;
    logic                  res_valid;
    logic                  res_ready;
    logic [INT_W-1:0]      res_interval;
    logic [IDX_W-1:0]      res_start_idx;
    logic [IDX_W-1:0]      res_stop_idx;
    logic [2:0]            res_status;
    logic [15:0]           err_count;

`ifdef TDC_DEC_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    tdc_hit_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .one_hot_start (one_hot_start),
        .one_hot_stop  (one_hot_stop),
        .out_count     (out_count),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_interval  (res_interval),
        .res_start_idx (res_start_idx),
        .res_stop_idx  (res_stop_idx),
        .res_status    (res_status),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INT_W-1:0] interval;
        logic [IDX_W-1:0] sidx;
        logic [IDX_W-1:0] pidx;
        logic [2:0]       status;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   err_model = 0;
    int   res_seen  = 0;
    int   accepted  = 0;

    // Directed vectors: bit positions (-1 = unused), count, hand-computed result
    localparam int NV = 10;
    int               v_sa  [NV] = '{10, 5, 4,  2, 203, 7,  0, -1, -1,  -1};
    int               v_sb  [NV] = '{-1, 9, -1, -1, -1, -1, -1, -1, -1,  -1};
    int               v_pa  [NV] = '{3,  1, -1, 50, 175, 7,  0, -1,  0, 100};
    int               v_pb  [NV] = '{-1, -1, -1, -1, -1, -1, -1, -1, 175, -1};
    logic [COUNT_W-1:0] v_cnt [NV] = '{2, 1, 0, 0, 3, 0, 48'hFFFF_FFFF_FFFF, 5, 1, 0};
    logic [INT_W-1:0] v_int [NV] = '{407, 0, 0, 0, 628, 0, 57'h0C7_FFFF_FFFF_FF38, 0, 0, 0};
    logic [2:0]       v_st  [NV] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b000,
                                     3'b000, 3'b000, 3'b011, 3'b011, 3'b101};
    logic [IDX_W-1:0] v_si  [NV] = '{10, 5, 4, 2, 203, 7, 0, 0, 0, 0};
    logic [IDX_W-1:0] v_pi  [NV] = '{3, 1, 0, 50, 175, 7, 0, 0, 0, 100};

    function automatic logic [START_TAPS-1:0] mk_start(input int a, input int b);
        logic [START_TAPS-1:0] v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [STOP_TAPS-1:0] mk_stop(input int a, input int b);
        logic [STOP_TAPS-1:0] v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [START_TAPS-1:0] st, input logic [STOP_TAPS-1:0] sp,
                        input logic [COUNT_W-1:0] c, input exp_t e, output int waited);
        one_hot_start = st;
        one_hot_stop  = sp;
        out_count     = c;
        in_valid      = 1'b1;
        sb_q.push_back(e);
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled expected=accepted");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        accepted++;
    endtask

    task automatic send_vec(input int i, output int waited);
        exp_t e;
        e.interval = v_int[i];
        e.sidx     = v_si[i];
        e.pidx     = v_pi[i];
        e.status   = v_st[i];
        send(mk_start(v_sa[i], v_sb[i]), mk_stop(v_pa[i], v_pb[i]), v_cnt[i], e, waited);
    endtask

    task automatic drain(input string name);
        int w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: pop and compare on every output handshake; held outputs must not move
    logic hold_vld = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check("stall_valid", 64'(res_valid), 64'd1);
                check("stall_interval", 64'(res_interval), 64'(held.interval));
                check("stall_start_idx", 64'(res_start_idx), 64'(held.sidx));
                check("stall_status", 64'(res_status), 64'(held.status));
            end
            if (res_valid && res_ready) begin
                res_seen++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=interval %0h expected=no result",
                             res_interval);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("res_interval", 64'(res_interval), 64'(e.interval));
                    check("res_start_idx", 64'(res_start_idx), 64'(e.sidx));
                    check("res_stop_idx", 64'(res_stop_idx), 64'(e.pidx));
                    check("res_status", 64'(res_status), 64'(e.status));
                    if (ERRCNT && e.status != 3'b000 && err_model < 65535) err_model++;
                end
            end
            hold_vld      = res_valid && !res_ready;
            held.interval = res_interval;
            held.sidx     = res_start_idx;
            held.pidx     = res_stop_idx;
            held.status   = res_status;
        end
    end

    initial begin
        int waited;
        int n;
        int seen_before;
        exp_t e;

        rst           = 1'b1;
        in_valid      = 1'b0;
        res_ready     = 1'b1;
        one_hot_start = '0;
        one_hot_stop  = '0;
        out_count     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_res_valid", 64'(res_valid), 64'd0);
        check("reset_interval", 64'(res_interval), 64'd0);
        check("reset_idx", 64'({res_start_idx, res_stop_idx}), 64'd0);
        check("reset_status", 64'(res_status), 64'd0);
        check("reset_err_count", 64'(err_count), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic capture with an empty pipe: result visible three cycles after accept
        send_vec(0, waited);
        n = 1;
        @(negedge clk);
        while (!res_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("latency_cycles", 64'(n), 64'd3);
        drain("drain_basic");
        @(posedge clk);
        #1;

        // Remaining vectors back to back; with res_ready high nothing may stall
        for (int i = 1; i < NV; i++) begin
            send_vec(i, waited);
            check("throughput_wait", 64'(waited), 64'd0);
        end
        drain("drain_vectors");
        check("err_count_vectors", 64'(err_count), 64'(err_model));

        // Backpressure: five captures while the consumer is stalled
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    e.interval = INT_W'(i * 200 + i + 1);
                    e.sidx     = IDX_W'(i + 1);
                    e.pidx     = '0;
                    e.status   = 3'b000;
                    send(mk_start(i + 1, -1), mk_stop(0, -1), COUNT_W'(i), e, waited);
                end
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                check("bp_accepted", 64'(accepted), 64'd3);
                check("bp_res_valid", 64'(res_valid), 64'd1);
                repeat (3) @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        check("err_count_backpressure", 64'(err_count), 64'(err_model));

        // Reset with two captures in flight
        @(posedge clk);
        #1;
        send_vec(0, waited);
        send_vec(1, waited);
        rst = 1'b1;
        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        sb_q.delete();
        err_model = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        seen_before = res_seen;
        repeat (10) @(negedge clk);
        check("rst_no_result", 64'(res_seen - seen_before), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_err_after", 64'(err_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
